// File: rtl/hazard_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : hazard_ctrl_if
// Description : Bundle between the decode/memory stages and the hazard
//               sequencer.
//               master : drives decode fields and br_taken, reads controls.
//               slave  : hazard_ctrl itself, reads decode fields and drives
//                        the stall/flush/issue controls and the counters.
// Ports       : id_valid, id_rs_a, id_rs_b, id_use_a, id_use_b, id_rd,
//               id_reg_write, br_taken        (master -> slave)
//               pc_stall, if_id_stall, id_ex_bubble, flush_if_id,
//               flush_id_ex, issue, stall_cnt, flush_cnt (slave -> master)
// Revision    : 1.0 - initial release
// ============================================================================
interface hazard_ctrl_if #(
  parameter int CNT_W = 16
);
  logic             id_valid;
  logic [3:0]       id_rs_a;
  logic [3:0]       id_rs_b;
  logic             id_use_a;
  logic             id_use_b;
  logic [3:0]       id_rd;
  logic             id_reg_write;
  logic             br_taken;

  logic             pc_stall;
  logic             if_id_stall;
  logic             id_ex_bubble;
  logic             flush_if_id;
  logic             flush_id_ex;
  logic             issue;
  logic [CNT_W-1:0] stall_cnt;
  logic [CNT_W-1:0] flush_cnt;

  modport master (
    output id_valid, id_rs_a, id_rs_b, id_use_a, id_use_b, id_rd,
           id_reg_write, br_taken,
    input  pc_stall, if_id_stall, id_ex_bubble, flush_if_id, flush_id_ex,
           issue, stall_cnt, flush_cnt
  );

  modport slave (
    input  id_valid, id_rs_a, id_rs_b, id_use_a, id_use_b, id_rd,
           id_reg_write, br_taken,
    output pc_stall, if_id_stall, id_ex_bubble, flush_if_id, flush_id_ex,
           issue, stall_cnt, flush_cnt
  );
endinterface
`default_nettype wire

// File: rtl/hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : hazard_ctrl
// Description : Issue/stall/flush sequencer for the 5-stage core without
//               forwarding. A scoreboard of in-flight register writes blocks
//               a decode read until the write lands; a taken branch resolved
//               in memory flushes the younger stages for FLUSH_CYCLES+1
//               cycles. Saturating counters track stall cycles and branches.
// Ports       : clk, rst          - clock, synchronous active-high reset
//               bus (slave)       - decode fields, br_taken in;
//                                   pc_stall, if_id_stall, id_ex_bubble,
//                                   flush_if_id, flush_id_ex, issue,
//                                   stall_cnt, flush_cnt out
// Revision    : 1.0 - initial release
// ============================================================================
module hazard_ctrl #(
  parameter int HAZ_DEPTH    = 3,
  parameter int BR_SLOT      = 1,
  parameter int FLUSH_CYCLES = 2,
  parameter int R0_ZERO      = 1,
  parameter int CNT_W        = 16
) (
  input  logic         clk,
  input  logic         rst,
  hazard_ctrl_if.slave bus
);

  localparam logic [1:0] S_RUN   = 2'd0;
  localparam logic [1:0] S_STALL = 2'd1;
  localparam logic [1:0] S_FLUSH = 2'd2;

  localparam int               FCNT_W    = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
  localparam logic [FCNT_W-1:0] FCNT_LOAD = FCNT_W'(FLUSH_CYCLES - 1);
  localparam bit               R0_IGN    = (R0_ZERO != 0);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  logic [1:0]                 state_q, state_d;
  logic [FCNT_W-1:0]          fcnt_q, fcnt_d;
  logic [HAZ_DEPTH-1:0]       slot_v_q;
  logic [HAZ_DEPTH-1:0][3:0]  slot_rd_q;
  logic [HAZ_DEPTH-1:0]       hit;
  logic                       hazard;
  logic [CNT_W-1:0]           stall_cnt_q;
  logic [CNT_W-1:0]           flush_cnt_q;

  logic pc_stall, if_id_stall, id_ex_bubble, flush_if_id, flush_id_ex, issue;

  // --------------------------------------------------------------------------
  // Scoreboard match: one comparator pair per in-flight slot
  // --------------------------------------------------------------------------
  for (genvar i = 0; i < HAZ_DEPTH; i++) begin : g_match
    assign hit[i] = slot_v_q[i]
                  && !(R0_IGN && (slot_rd_q[i] == 4'd0))
                  && ((bus.id_use_a && (slot_rd_q[i] == bus.id_rs_a))
                   || (bus.id_use_b && (slot_rd_q[i] == bus.id_rs_b)));
  end

  assign hazard = bus.id_valid & (|hit);

  // Slots shift every cycle regardless of stall so older writes keep
  // retiring. On a taken branch the entries younger than the branch are
  // wrong-path and get dropped as they move.
  always_ff @(posedge clk) begin
    if (rst) begin
      slot_v_q  <= '0;
      slot_rd_q <= '0;
    end else begin
      slot_v_q[0]  <= issue & bus.id_reg_write;
      slot_rd_q[0] <= bus.id_rd;
      for (int i = 1; i < HAZ_DEPTH; i++) begin
        slot_v_q[i]  <= slot_v_q[i-1] & ~(bus.br_taken & ((i - 1) < BR_SLOT));
        slot_rd_q[i] <= slot_rd_q[i-1];
      end
    end
  end

  // --------------------------------------------------------------------------
  // FSM: state register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_RUN;
      fcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      fcnt_q  <= fcnt_d;
    end
  end

  // --------------------------------------------------------------------------
  // FSM: next state (branch takes priority over everything)
  // --------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    fcnt_d  = fcnt_q;
    if (bus.br_taken) begin
      state_d = S_FLUSH;
      fcnt_d  = FCNT_LOAD;
    end else begin
      case (state_q)
        S_RUN, S_STALL: state_d = hazard ? S_STALL : S_RUN;
        S_FLUSH: begin
          if (fcnt_q == '0) state_d = S_RUN;
          else              fcnt_d  = fcnt_q - 1'b1;
        end
        default: state_d = S_RUN;
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // FSM: outputs. RUN and STALL share one rule driven by the live hazard,
  // so the cycle the hazard clears already issues.
  // --------------------------------------------------------------------------
  always_comb begin
    pc_stall     = 1'b0;
    if_id_stall  = 1'b0;
    id_ex_bubble = 1'b1;
    flush_if_id  = 1'b0;
    flush_id_ex  = 1'b0;
    issue        = 1'b0;
    if (rst) begin
      id_ex_bubble = 1'b1;
    end else if (bus.br_taken || (state_q == S_FLUSH)) begin
      flush_if_id  = 1'b1;
      flush_id_ex  = 1'b1;
      id_ex_bubble = 1'b1;
    end else begin
      pc_stall     = hazard;
      if_id_stall  = hazard;
      id_ex_bubble = hazard | ~bus.id_valid;
      issue        = bus.id_valid & ~hazard;
    end
  end

  // --------------------------------------------------------------------------
  // Saturating performance counters
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      if (hazard && !bus.br_taken && (stall_cnt_q != '1))
        stall_cnt_q <= stall_cnt_q + CNT_ONE;
      if (bus.br_taken && (flush_cnt_q != '1))
        flush_cnt_q <= flush_cnt_q + CNT_ONE;
    end
  end

  assign bus.pc_stall     = pc_stall;
  assign bus.if_id_stall  = if_id_stall;
  assign bus.id_ex_bubble = id_ex_bubble;
  assign bus.flush_if_id  = flush_if_id;
  assign bus.flush_id_ex  = flush_id_ex;
  assign bus.issue        = issue;
  assign bus.stall_cnt    = stall_cnt_q;
  assign bus.flush_cnt    = flush_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_hazard_ctrl
// Description : Self-checking bench for hazard_ctrl. A reference model keeps
//               the list of issued writes with their issue cycle and derives
//               hazards from write age; flushes are a remaining-cycle count.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_hazard_ctrl;

  localparam int HAZ_DEPTH    = 3;
  localparam int BR_SLOT      = 1;
  localparam int FLUSH_CYCLES = 2;
  localparam int R0_ZERO      = 1;
  localparam int CNT_W        = 16;
  localparam int CNT_MAX      = (1 << CNT_W) - 1;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  hazard_ctrl_if #(.CNT_W(CNT_W)) bus ();

  hazard_ctrl #(
    .HAZ_DEPTH(HAZ_DEPTH), .BR_SLOT(BR_SLOT), .FLUSH_CYCLES(FLUSH_CYCLES),
    .R0_ZERO(R0_ZERO), .CNT_W(CNT_W)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.slave)
  );

  typedef struct {
    logic [3:0] rd;
    int         t;
    bit         killed;
  } wr_t;

  wr_t wq[$];
  int  cyc;
  int  flush_rem;
  int  m_stall;
  int  m_flush;
  bit  cnt_known;
  int  checks;
  int  errors;

  logic o_issue, o_pcst, o_ifst, o_bub, o_fif, o_fex;
  logic [CNT_W-1:0] o_scnt, o_fcnt;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // A write issued at cycle t blocks readers during cycles t+1 .. t+HAZ_DEPTH.
  function automatic bit m_hazard();
    if (!bus.id_valid) return 1'b0;
    foreach (wq[k]) begin
      int age;
      age = cyc - wq[k].t;
      if (!wq[k].killed && age >= 1 && age <= HAZ_DEPTH
          && !(R0_ZERO != 0 && wq[k].rd == 4'd0)
          && ((bus.id_use_a && wq[k].rd == bus.id_rs_a)
           || (bus.id_use_b && wq[k].rd == bus.id_rs_b)))
        return 1'b1;
    end
    return 1'b0;
  endfunction

  task automatic drive(input bit v, input int ra, input bit ua, input int rb,
                       input bit ub, input int rd, input bit wr, input bit br);
    bus.id_valid     = v;
    bus.id_rs_a      = 4'(ra);
    bus.id_use_a     = ua;
    bus.id_rs_b      = 4'(rb);
    bus.id_use_b     = ub;
    bus.id_rd        = 4'(rd);
    bus.id_reg_write = wr;
    bus.br_taken     = br;
  endtask

  task automatic idle();
    drive(0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  // Called at negedge with inputs applied: check this cycle, then advance.
  task automatic step();
    bit haz, br, e_iss, e_st, e_bub, e_fl;
    #1;
    haz = m_hazard();
    br  = bus.br_taken;
    if (rst) begin
      e_iss = 0; e_st = 0; e_bub = 1; e_fl = 0;
    end else if (br || flush_rem > 0) begin
      e_iss = 0; e_st = 0; e_bub = 1; e_fl = 1;
    end else if (haz) begin
      e_iss = 0; e_st = 1; e_bub = 1; e_fl = 0;
    end else begin
      e_iss = bus.id_valid; e_st = 0; e_bub = !bus.id_valid; e_fl = 0;
    end
    o_issue = bus.issue;       o_pcst = bus.pc_stall;   o_ifst = bus.if_id_stall;
    o_bub   = bus.id_ex_bubble; o_fif = bus.flush_if_id; o_fex = bus.flush_id_ex;
    o_scnt  = bus.stall_cnt;   o_fcnt = bus.flush_cnt;
    chk("issue",        32'(o_issue), 32'(e_iss));
    chk("pc_stall",     32'(o_pcst),  32'(e_st));
    chk("if_id_stall",  32'(o_ifst),  32'(e_st));
    chk("id_ex_bubble", 32'(o_bub),   32'(e_bub));
    chk("flush_if_id",  32'(o_fif),   32'(e_fl));
    chk("flush_id_ex",  32'(o_fex),   32'(e_fl));
    if (cnt_known) begin
      chk("stall_cnt", 32'(o_scnt), 32'(m_stall));
      chk("flush_cnt", 32'(o_fcnt), 32'(m_flush));
    end
    @(posedge clk);
    if (rst) begin
      wq.delete();
      flush_rem = 0;
      m_stall   = 0;
      m_flush   = 0;
      cnt_known = 1;
    end else begin
      if (br) begin
        foreach (wq[k]) if (wq[k].t >= cyc - BR_SLOT) wq[k].killed = 1;
        flush_rem = FLUSH_CYCLES;
        if (m_flush < CNT_MAX) m_flush++;
      end else if (flush_rem > 0) begin
        flush_rem--;
      end
      if (haz && !br && m_stall < CNT_MAX) m_stall++;
      if (e_iss && bus.id_reg_write) begin
        wr_t w;
        w.rd = bus.id_rd; w.t = cyc; w.killed = 0;
        wq.push_back(w);
      end
    end
    cyc++;
    while (wq.size() > 0 && cyc - wq[0].t > HAZ_DEPTH) void'(wq.pop_front());
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1;
    idle();
    step();
    step();
    rst = 0;
  endtask

  initial begin
    int n;
    bit done;
    checks = 0; errors = 0; cyc = 0; flush_rem = 0;
    m_stall = 0; m_flush = 0; cnt_known = 0;
    rst = 1;
    idle();
    @(posedge clk);
    cnt_known = 1;
    @(negedge clk);

    // 1: three reset cycles, then idle decode
    step();
    step();
    rst = 0;
    idle();
    step();
    chk("t1_issue",  32'(o_issue), 0);
    chk("t1_bubble", 32'(o_bub),   1);
    chk("t1_stall",  32'(o_pcst),  0);
    chk("t1_scnt",   32'(o_scnt),  0);
    chk("t1_fcnt",   32'(o_fcnt),  0);

    // 2: RAW on r5 stalls three cycles
    do_reset();
    drive(1, 0, 0, 0, 0, 5, 1, 0);
    step();
    chk("t2_writer_issue", 32'(o_issue), 1);
    drive(1, 5, 1, 0, 0, 0, 0, 0);
    n = 0; done = 0;
    for (int k = 0; k < 10; k++) begin
      step();
      if (o_issue) begin
        done = 1;
        break;
      end
      n++;
    end
    chk("t2_reader_issued", 32'(done), 1);
    chk("t2_stall_cycles",  32'(n),    3);
    idle();
    step();
    chk("t2_stall_cnt", 32'(o_scnt), 3);

    // 3: writes to r0 never block
    do_reset();
    drive(1, 0, 0, 0, 0, 0, 1, 0);
    step();
    chk("t3_first_issue", 32'(o_issue), 1);
    drive(1, 0, 1, 0, 1, 0, 0, 0);
    step();
    chk("t3_second_issue", 32'(o_issue), 1);
    chk("t3_no_stall",     32'(o_pcst),  0);

    // 4: single taken branch flushes three cycles
    do_reset();
    idle();
    bus.br_taken = 1;
    step();
    chk("t4_flush_now", 32'(o_fif), 1);
    bus.br_taken = 0;
    n = 1;
    for (int k = 0; k < 5; k++) begin
      step();
      if (o_fif) n++;
    end
    chk("t4_flush_cycles", 32'(n),      3);
    chk("t4_flush_cnt",    32'(o_fcnt), 1);

    // 5: branch and hazard in the same cycle
    do_reset();
    drive(1, 0, 0, 0, 0, 7, 1, 0);
    step();
    drive(1, 7, 1, 0, 0, 0, 0, 1);
    step();
    chk("t5_issue", 32'(o_issue), 0);
    chk("t5_flush", 32'(o_fex),   1);
    chk("t5_stall", 32'(o_pcst),  0);
    idle();
    step();
    chk("t5_stall_cnt", 32'(o_scnt), 0);
    chk("t5_in_flush",  32'(o_fif),  1);

    // 6: reset in the middle of a flush
    do_reset();
    idle();
    bus.br_taken = 1;
    step();
    bus.br_taken = 0;
    rst = 1;
    step();
    chk("t6_rst_flush",  32'(o_fif),   0);
    chk("t6_rst_issue",  32'(o_issue), 0);
    chk("t6_rst_bubble", 32'(o_bub),   1);
    rst = 0;
    step();
    chk("t6_after_flush",  32'(o_fex),  0);
    chk("t6_after_bubble", 32'(o_bub),  1);
    chk("t6_after_scnt",   32'(o_scnt), 0);
    chk("t6_after_fcnt",   32'(o_fcnt), 0);

    // Random traffic; decode is held empty while the model is flushing
    do_reset();
    for (int k = 0; k < 4000; k++) begin
      rst = ($urandom_range(0, 199) == 0);
      drive((flush_rem == 0) && ($urandom_range(0, 3) != 0),
            $urandom_range(0, 7), 1'($urandom_range(0, 1)),
            $urandom_range(0, 7), 1'($urandom_range(0, 1)),
            $urandom_range(0, 7), 1'($urandom_range(0, 1)),
            ($urandom_range(0, 11) == 0));
      step();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
